// File: rtl/f_subs.sv
// Registered full subtractor: {E, D} = A - B - C at WIDTH+1 bits, one cycle latency.
// Optional macro F_SUBS_SERIAL_EN feeds the registered borrow-out back as borrow-in.

module f_subs_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

module f_subs #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C,
   output logic [WIDTH-1:0] D,
   output logic             E
);
   logic [WIDTH:0]   bw;
   logic [WIDTH-1:0] d_n;
   logic             c_eff;

`ifdef F_SUBS_SERIAL_EN
   // previous slice's borrow chains into this one; reset clears E so C starts the word
   assign c_eff = C | E;
`else
   assign c_eff = C;
`endif

   assign bw[0] = c_eff;

   // ripple borrow chain; bw[WIDTH] is set exactly when A < B + C
   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      f_subs_cell u_cell (
         .a   (A[g]),
         .b   (B[g]),
         .bin (bw[g]),
         .d   (d_n[g]),
         .bout(bw[g+1])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         D <= '0;
         E <= 1'b0;
      end else begin
         D <= d_n;
         E <= bw[WIDTH];
      end
   end
endmodule

// File: tb/tb_f_subs.sv
// Scoreboard bench for f_subs: 1-bit and 8-bit instances side by side.
module tb_f_subs;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       c8 = 1'b0;
   logic       d1, e1;
   logic [7:0] d8;
   logic       e8;

   int checks = 0;
   int errors = 0;

   logic [1:0] q1[$];   // {E, D}
   logic [8:0] q8[$];   // {E, D}

   always #5 clk = ~clk;

   f_subs #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .A(a1), .B(b1), .C(c1), .D(d1), .E(e1));
   f_subs #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .A(a8), .B(b8), .C(c8), .D(d8), .E(e8));

   task automatic test_reset();
      logic [1:0] x1;
      logic [8:0] x8;
      rst = 1'b1; a1 = 1; b1 = 0; c1 = 1; a8 = 8'h01; b8 = 8'h00; c8 = 1;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) rst = 1'b0;   // 1 - 0 - 1 = 0, no borrow
         q1.push_back(2'b00);
         q8.push_back(9'h000);
         @(posedge clk); #1;
         x1 = q1.pop_front();
         x8 = q8.pop_front();
         checks++;
         if ({e1, d1} !== x1) begin
            errors++;
            $display("FAIL reset1[%0d] got E=%b D=%b exp E=%b D=%b", i, e1, d1, x1[1], x1[0]);
         end
         checks++;
         if ({e8, d8} !== x8) begin
            errors++;
            $display("FAIL reset8[%0d] got E=%b D=%h exp E=%b D=%h", i, e8, d8, x8[8], x8[7:0]);
         end
      end
   endtask

   task automatic test_sweep();
      logic [1:0] exp_tab [8] = '{2'd0, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd3};
      logic [2:0] v;
      logic [1:0] x1;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         {a1, b1, c1} = v;
         q1.push_back(exp_tab[i]);
         @(posedge clk); #1;
         x1 = q1.pop_front();
         checks++;
         if ({e1, d1} !== x1) begin
            errors++;
            $display("FAIL sweep abc=%b got E=%b D=%b exp E=%b D=%b", v, e1, d1, x1[1], x1[0]);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [1:0] x1;
      {a1, b1, c1} = 3'b011;
      for (int i = 0; i < 2; i++) begin
         rst = (i == 0);
         q1.push_back(i == 0 ? 2'b00 : 2'b10);
         @(posedge clk); #1;
         x1 = q1.pop_front();
         checks++;
         if ({e1, d1} !== x1) begin
            errors++;
            $display("FAIL mid_reset[%0d] got E=%b D=%b exp E=%b D=%b", i, e1, d1, x1[1], x1[0]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_width8();
      logic [7:0] ta [3] = '{8'h00, 8'h80, 8'h55};
      logic [7:0] tb [3] = '{8'hFF, 8'h01, 8'h55};
      logic       tc [3] = '{1'b1, 1'b0, 1'b0};
      logic [8:0] te [3] = '{9'h100, 9'h07F, 9'h000};
      logic [8:0] x8;
      for (int i = 0; i < 7; i++) begin
         if (i < 3) begin
            a8 = ta[i]; b8 = tb[i]; c8 = tc[i];
            q8.push_back(te[i]);
         end else begin
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            q8.push_back({1'b0, a8} - {1'b0, b8} - {8'd0, c8});
         end
         @(posedge clk); #1;
         x8 = q8.pop_front();
         checks++;
         if ({e8, d8} !== x8) begin
            errors++;
            $display("FAIL width8[%0d] got E=%b D=%h exp E=%b D=%h", i, e8, d8, x8[8], x8[7:0]);
         end
      end
   endtask

   task automatic test_latency();
      logic [1:0] x1;
      {a1, b1, c1} = 3'b100;
      q1.push_back(2'b01);
      @(posedge clk); #1;
      x1 = q1.pop_front();
      checks++;
      if ({e1, d1} !== x1) begin
         errors++;
         $display("FAIL latency_a got E=%b D=%b exp E=%b D=%b", e1, d1, x1[1], x1[0]);
      end
      {a1, b1, c1} = 3'b010;   // would give E=1 D=1 if it leaked through
      #2;
      checks++;
      if ({e1, d1} !== x1) begin
         errors++;
         $display("FAIL latency_hold got E=%b D=%b exp E=%b D=%b", e1, d1, x1[1], x1[0]);
      end
      q1.push_back(2'b11);
      @(posedge clk); #1;
      x1 = q1.pop_front();
      checks++;
      if ({e1, d1} !== x1) begin
         errors++;
         $display("FAIL latency_b got E=%b D=%b exp E=%b D=%b", e1, d1, x1[1], x1[0]);
      end
   endtask

`ifdef F_SUBS_SERIAL_EN
   task automatic test_serial();
      logic [7:0] wa = 8'h10;
      logic [7:0] wb = 8'h01;
      logic [7:0] dexp = 8'h0F;
      logic [7:0] dgot;
      logic [1:0] x1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; c1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         a1 = wa[i]; b1 = wb[i];
         q1.push_back({(i < 4), dexp[i]});
         @(posedge clk); #1;
         dgot[i] = d1;
         x1 = q1.pop_front();
         checks++;
         if ({e1, d1} !== x1) begin
            errors++;
            $display("FAIL serial[%0d] got E=%b D=%b exp E=%b D=%b", i, e1, d1, x1[1], x1[0]);
         end
      end
      checks++;
      if (dgot !== dexp || e1 !== 1'b0) begin
         errors++;
         $display("FAIL serial_word got D=%h E=%b exp D=%h E=0", dgot, e1, dexp);
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef F_SUBS_SERIAL_EN
      test_serial();
`else
      test_sweep();
      test_mid_reset();
      test_width8();
      test_latency();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/f_subs.md
# f_subs

Registered full subtractor. It computes the difference and borrow-out of A − B − C, where C is the borrow-in. The width is parameterizable; the default is 1 bit, the classic full subtractor. It is a leaf arithmetic cell used standalone or chained (borrow-out to the next stage's borrow-in) to build multi-bit or bit-serial subtractors. Outputs are registered on the single clock and cleared by synchronous reset.

## Interface
Parameters:
- WIDTH, 1, operand and difference width in bits (≥1)

Ports:
- clk  input  1  rising-edge clock; the only clock in the block
- rst  input  1  synchronous, active-high reset
- A  input  WIDTH  minuend, unsigned
- B  input  WIDTH  subtrahend, unsigned
- C  input  1  borrow-in
- D  output  WIDTH  difference, registered
- E  output  1  borrow-out, registered

## Operation
- Combinational core computes {E_n, D_n} = {1'b0, A} − {1'b0, B} − C, evaluated at WIDTH+1 bits.
- D_n is the low WIDTH bits: (A − B − C) mod 2^WIDTH.
- E_n = 1 exactly when A < B + C as unsigned values; otherwise 0.
- For WIDTH=1 this reduces to the following:
  - D_n = A ^ B ^ C.
  - E_n = (~A & B) | (~A & C) | (B & C).
- Registers capture D_n and E_n every rising clk edge when rst=0.
- There is no enable and no valid handshake; every cycle is a new operation.
- Inputs are treated as unsigned; no signed overflow flag is produced.
- Corner cases:
  - With all inputs 0, the result is D=0, E=0.
  - With A=0, B=all-ones, C=1, the result is D=0, E=1 (full wrap).
  - With A=B and C=0, the result is D=0, E=0.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on D/E after edge N and are held until edge N+1.
- Reset: when rst=1 at a rising edge, D←0 and E←0 regardless of inputs.
  - Reset has priority over computation.
  - Outputs stay 0 for every edge at which rst is high.
  - The first valid result appears one edge after rst deasserts.
- Reset asserted mid-stream discards the in-flight result.
- Input changes between edges have no effect on the outputs; there are no combinational paths from inputs to outputs.
- Until the first clock edge after power-up, outputs are undefined. The bench applies reset first.

## Configuration
- Macro: F_SUBS_SERIAL_EN.
- Undefined (default): the effective borrow-in is C; behaviour is exactly as above.
- Defined: bit-serial chaining mode.
  - The effective borrow-in is C | E, where E is the registered borrow-out from the previous cycle.
  - This lets a WIDTH-bit slice process a long word LSB-slice-first, one slice per cycle.
  - C injects an external initial borrow.
  - Reset clears E, so the first slice after reset uses C alone.
  - Port list and latency are unchanged.

## Test plan
- Reset:
  - Drive rst=1 with A=1, B=0, C=1 for 2 edges → D=0, E=0.
  - Release rst → next edge D=0, E=0 (1−0−1).
- WIDTH=1 exhaustive sweep, each vector held ≥1 edge; each result is checked one edge later.
  - ABC=000→D0 E0, 001→D1 E1, 010→D1 E1, 011→D0 E1.
  - 100→D1 E0, 101→D0 E0, 110→D0 E0, 111→D1 E1.
- Mid-stream reset: apply ABC=011 and assert rst on the same edge → D=0, E=0. The next edge with rst=0 → D=0, E=1.
- WIDTH=8 boundaries:
  - A=0x00, B=0xFF, C=1 → D=0x00, E=1.
  - A=0x80, B=0x01, C=0 → D=0x7F, E=0.
  - A=0x55, B=0x55, C=0 → D=0x00, E=0.
- Latency check: change inputs between edges → D/E change only at the next rising edge, never combinationally.
- With F_SUBS_SERIAL_EN, WIDTH=1, after reset, feed 0x10 − 0x01 LSB-first with C=0:
  - Serial D bits are 1,1,1,1,0,0,0,0, giving 0x0F.
  - Final E=0.
